// File: rtl/psc_trigger_pkg.sv
// Shared definitions for the PSC trigger serialiser.
//   state_e         : frame FSM states (IDLE, LOAD, SHIFT, GAP)
//   CRC_POLY        : CRC-8 polynomial used for the optional trailing byte
//   BITS_PER_BYTE   : start + 8 data + stop
//   GAP_BITS        : idle-high bit periods between frames
//   frame_bytes()   : number of bytes per frame for a given CRC setting
package psc_trigger_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StGap
    } state_e;

    localparam logic [7:0]  CRC_POLY      = 8'h07;
    localparam int unsigned BITS_PER_BYTE = 10;
    localparam int unsigned GAP_BITS      = 2;

    function automatic int unsigned frame_bytes(input bit crc_en);
        return crc_en ? 32'd4 : 32'd3;
    endfunction

endpackage

// File: rtl/psc_trigger_crc8.sv
// Bytewise CRC-8 update (MSB first, no reflection, no final xor).
//   crc_in  : running CRC before this byte
//   data_in : byte to fold in
//   crc_out : running CRC after this byte
module psc_trigger_crc8
    import psc_trigger_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/psc_trigger_tx.sv
// Trigger-to-serial frame transmitter.
// Each rising edge on an evr_trigger channel queues one frame
// {SYNC_BYTE, channel, seq[, crc]} sent as 8N1 bytes on psc_output, each bit
// held CLK_DIV clocks. Channels are served round-robin.
//   clk         : single clock
//   reset       : synchronous, active-low
//   evr_trigger : asynchronous per-channel trigger inputs
//   psc_output  : serial frame line, idle high
//   busy        : high in LOAD, SHIFT and GAP
//   drop_pulse  : one-cycle pulse when an edge hits an already pending channel
// Build option: define PSC_TRIGGER_CRC_EN to append a CRC-8 byte (4-byte frames).
module psc_trigger_tx
    import psc_trigger_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CLK_DIV   = 5,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] evr_trigger,
    output logic              psc_output,
    output logic              busy,
    output logic              drop_pulse
);

    localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DivW = $clog2(CLK_DIV);
`ifdef PSC_TRIGGER_CRC_EN
    localparam bit CrcEn = 1'b1;
`else
    localparam bit CrcEn = 1'b0;
`endif
    localparam int unsigned     NumBytes = frame_bytes(CrcEn);
    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [3:0]      BitLast  = 4'(BITS_PER_BYTE - 1);
    localparam logic [3:0]      GapLast  = 4'(GAP_BITS - 1);
    localparam logic [1:0]      ByteLast = 2'(NumBytes - 1);

    state_e state_q, state_d;

    logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [NUM_CH-1:0] edge_q, edge_d, pending_q, pending_d;
    logic [ChW-1:0]    rr_q, rr_d, ch_q, ch_d;
    logic [7:0]        seq_q, seq_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [3:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;

    logic [NUM_CH-1:0] grant_vec;
    logic [ChW-1:0]    grant_idx;
    logic              found;
    int unsigned       idx;
    logic              div_last;
    logic [7:0]        cur_byte;

`ifdef PSC_TRIGGER_CRC_EN
    logic [7:0] crc_q, crc_d, crc_next;

    psc_trigger_crc8 u_crc8 (
        .crc_in  (crc_q),
        .data_in (cur_byte),
        .crc_out (crc_next)
    );
`endif

    assign div_last = (div_q == DivLast);

    // Round-robin pick, only evaluated while in LOAD.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (state_q == StLoad) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                idx = (32'(rr_q) + k) % NUM_CH;
                if (!found && pending_q[ChW'(idx)]) begin
                    found               = 1'b1;
                    grant_idx           = ChW'(idx);
                    grant_vec[ChW'(idx)] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cur_byte = 8'hFF;
        case (byte_q)
            2'd0:    cur_byte = SYNC_BYTE;
            2'd1:    cur_byte = 8'(ch_q);
            2'd2:    cur_byte = seq_q;
`ifdef PSC_TRIGGER_CRC_EN
            2'd3:    cur_byte = crc_q;
`endif
            default: cur_byte = 8'hFF;
        endcase
    end

    // Input conditioning and pending bookkeeping; a same-cycle edge beats the grant clear.
    always_comb begin
        sync1_d   = evr_trigger;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        edge_d    = sync2_q & ~prev_q;
        pending_d = (pending_q & ~grant_vec) | edge_q;
        rr_d      = found ? ChW'((32'(grant_idx) + 32'd1) % NUM_CH) : rr_q;
        ch_d      = found ? grant_idx : ch_q;
    end

    // Bit timing, byte sequencing and frame counter.
    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        byte_d = byte_q;
        seq_d  = seq_q;
`ifdef PSC_TRIGGER_CRC_EN
        crc_d  = crc_q;
`endif
        case (state_q)
            StLoad: begin
                div_d  = '0;
                bit_d  = '0;
                byte_d = '0;
`ifdef PSC_TRIGGER_CRC_EN
                crc_d  = '0;
`endif
            end
            StShift: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == BitLast) begin
                        bit_d  = '0;
                        byte_d = byte_q + 2'd1;
                        if (byte_q == ByteLast) begin
                            seq_d = seq_q + 8'd1;
                        end
`ifdef PSC_TRIGGER_CRC_EN
                        else begin
                            crc_d = crc_next;
                        end
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StGap: begin
                if (div_last) begin
                    div_d = '0;
                    bit_d = bit_q + 4'd1;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (|pending_q) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (div_last && bit_q == BitLast && byte_q == ByteLast) state_d = StGap;
            StGap:   if (div_last && bit_q == GapLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        psc_output = 1'b1;
        busy       = (state_q != StIdle);
        drop_pulse = |(edge_q & pending_q & ~grant_vec);
        if (state_q == StShift) begin
            if (bit_q == 4'd0) begin
                psc_output = 1'b0;
            end else if (bit_q != BitLast) begin
                psc_output = cur_byte[3'(bit_q - 4'd1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            rr_q      <= '0;
            ch_q      <= '0;
            seq_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
`ifdef PSC_TRIGGER_CRC_EN
            crc_q     <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            edge_q    <= edge_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            ch_q      <= ch_d;
            seq_q     <= seq_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
`ifdef PSC_TRIGGER_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_psc_trigger_tx.sv
module tb_psc_trigger_tx;

    localparam int D  = 5;
    localparam int D1 = 2;
`ifdef PSC_TRIGGER_CRC_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int BUSY_LEN  = 1 + NB * 10 * D + 2 * D;
    localparam int BUSY1_LEN = 1 + NB * 10 * D1 + 2 * D1;

    logic       clk;
    logic       reset;
    logic [3:0] trig;
    logic       psc_output, busy, drop_pulse;
    logic [0:0] trig1;
    logic       psc_output1, busy1, drop_pulse1;

    psc_trigger_tx #(.NUM_CH(4), .CLK_DIV(D), .SYNC_BYTE(8'hA5)) dut (
        .clk         (clk),
        .reset       (reset),
        .evr_trigger (trig),
        .psc_output  (psc_output),
        .busy        (busy),
        .drop_pulse  (drop_pulse)
    );

    psc_trigger_tx #(.NUM_CH(1), .CLK_DIV(D1), .SYNC_BYTE(8'hA5)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .evr_trigger (trig1),
        .psc_output  (psc_output1),
        .busy        (busy1),
        .drop_pulse  (drop_pulse1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] seq_model;
    int         rx_cnt   = 0;
    int         drop_cnt = 0;
    int         b2b_cnt  = 0;
    int         rise1    = 0;
    int         drop1    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] ch);
        logic [7:0] c;
        exp_q.push_back(8'hA5);
        exp_q.push_back(ch);
        exp_q.push_back(seq_model);
        if (NB == 4) begin
            c = crc8(crc8(crc8(8'h00, 8'hA5), ch), seq_model);
            exp_q.push_back(c);
        end
        seq_model = seq_model + 8'd1;
    endtask

    // Serial decoder for the main DUT: samples each bit mid-period, pops the scoreboard.
    initial begin
        int         rx_c;
        int         k;
        logic       rx_act;
        logic [7:0] rx_sh;
        rx_act = 1'b0;
        rx_c   = 0;
        rx_sh  = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (psc_output === 1'b0) begin
                    rx_act = 1'b1;
                    rx_c   = 0;
                end
            end else begin
                rx_c++;
                if (rx_c % D == D / 2) begin
                    k = rx_c / D;
                    if (k >= 1 && k <= 8) begin
                        rx_sh[k-1] = psc_output;
                    end else if (k == 9) begin
                        rx_act = 1'b0;
                        check("stop_bit", {31'd0, psc_output}, 32'd1);
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_err++;
                            $display("FAIL rx_byte: got 0x%0h, expected no byte", rx_sh);
                        end else begin
                            check("rx_byte", {24'd0, rx_sh}, {24'd0, exp_q.pop_front()});
                        end
                        rx_cnt++;
                    end
                end
            end
        end
    end

    // Busy-run length, back-to-back frame detection and drop counting.
    initial begin
        int   run;
        int   idle_run;
        int   run1;
        logic prev_busy;
        logic prev_busy1;
        run = 0; idle_run = 0; run1 = 0; prev_busy = 1'b0; prev_busy1 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                run = 0; idle_run = 0; run1 = 0; prev_busy = 1'b0; prev_busy1 = 1'b0;
            end else begin
                if (busy === 1'b1) begin
                    if (!prev_busy && idle_run == 1) b2b_cnt++;
                    run++;
                    idle_run = 0;
                end else begin
                    if (run > 0) check("busy_len", run, BUSY_LEN);
                    run = 0;
                    idle_run++;
                end
                prev_busy = (busy === 1'b1);
                if (drop_pulse === 1'b1) drop_cnt++;
                if (busy1 === 1'b1) begin
                    if (!prev_busy1) rise1++;
                    run1++;
                end else begin
                    if (run1 > 0) check("busy1_len", run1, BUSY1_LEN);
                    run1 = 0;
                end
                prev_busy1 = (busy1 === 1'b1);
                if (drop_pulse1 === 1'b1) drop1++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_psc_output", {31'd0, psc_output}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop", {31'd0, drop_pulse}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        seq_model = 8'd0;
    endtask

    task automatic pulse(input logic [3:0] mask);
        @(posedge clk);
        #1 trig = mask;
        repeat (2) @(posedge clk);
        #1 trig = 4'd0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int  idle;
        int  n;
        bit  done;
        idle = 0; n = 0; done = 1'b0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) idle++;
            else idle = 0;
            if (idle >= 6 && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout_%s: busy=%b, %0d bytes still expected", tag, busy, exp_q.size());
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        int         nfr;
        logic [1:0] ord [4];
    } vec_t;

    vec_t tbl[7];

    function automatic vec_t mk(input logic [3:0] m, input int n, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
        vec_t v;
        v.mask = m; v.nfr = n;
        v.ord[0] = a; v.ord[1] = b; v.ord[2] = c; v.ord[3] = d;
        return v;
    endfunction

    initial begin
        int d0, b0, target, n;
        reset     = 1'b0;
        trig      = 4'd0;
        trig1     = 1'b0;
        seq_model = 8'd0;

        // Round-robin order from rr_ptr = 0 straight after reset.
        tbl[0] = mk(4'b1001, 2, 2'd0, 2'd3, 2'd0, 2'd0); // rr back to 0
        tbl[1] = mk(4'b1010, 2, 2'd1, 2'd3, 2'd0, 2'd0); // proves rr was 0
        tbl[2] = mk(4'b0100, 1, 2'd2, 2'd0, 2'd0, 2'd0); // rr -> 3
        tbl[3] = mk(4'b1111, 4, 2'd3, 2'd0, 2'd1, 2'd2); // rr -> 3
        tbl[4] = mk(4'b0010, 1, 2'd1, 2'd0, 2'd0, 2'd0); // rr -> 2
        tbl[5] = mk(4'b0110, 2, 2'd2, 2'd1, 2'd0, 2'd0); // rr -> 2
        tbl[6] = mk(4'b1001, 2, 2'd3, 2'd0, 2'd0, 2'd0);

        do_reset();

        // Latency: start bit 5 edges after the first edge sampling the trigger.
        push_frame(8'd2);
        @(posedge clk);
        #1 trig = 4'b0100;
        @(posedge clk);              // E0 samples trigger high
        repeat (3) @(posedge clk);   // E3
        @(negedge clk);
        check("lat_busy_e3", {31'd0, busy}, 32'd0);
        @(posedge clk);              // E4: LOAD
        @(negedge clk);
        check("lat_busy_e4", {31'd0, busy}, 32'd1);
        check("lat_psc_e4", {31'd0, psc_output}, 32'd1);
        @(posedge clk);              // E5: start bit
        @(negedge clk);
        check("lat_psc_e5", {31'd0, psc_output}, 32'd0);
        trig = 4'd0;
        wait_idle("latency");

        do_reset();
        for (int i = 0; i < 7; i++) begin
            d0 = drop_cnt;
            b0 = b2b_cnt;
            for (int k = 0; k < tbl[i].nfr; k++) push_frame({6'd0, tbl[i].ord[k]});
            pulse(tbl[i].mask);
            wait_idle("table");
            check("table_drop", drop_cnt - d0, 0);
            check("table_b2b", b2b_cnt - b0, tbl[i].nfr - 1);
        end

        // Two more ch1 edges while ch1 is already pending and a frame is in flight.
        d0 = drop_cnt;
        push_frame(8'd1);
        push_frame(8'd1);
        pulse(4'b0010);
        repeat (20) @(posedge clk);
        pulse(4'b0010);
        pulse(4'b0010);
        wait_idle("drop");
        check("drop_count", drop_cnt - d0, 1);

        // 257 frames on ch0: seq 00..FF then wraps to 00.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            push_frame(8'd0);
            pulse(4'b0001);
            wait_idle("seq_run");
        end
        check("seq_model_wrapped", {24'd0, seq_model}, 32'd1);

        // Reset in the middle of the seq byte, then seq restarts at 00.
        do_reset();
        push_frame(8'd2);
        pulse(4'b0100);
        target = rx_cnt + 2;
        n = 0;
        while (rx_cnt < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("midframe_bytes_seen", (rx_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
        repeat (2 * D) @(posedge clk);
        check("midframe_busy_before", {31'd0, busy}, 32'd1);
        do_reset();
        push_frame(8'd1);
        pulse(4'b0010);
        wait_idle("after_reset");

        // Single-channel, CLK_DIV=2 instance: a held-high trigger is one edge.
        d0 = rise1;
        @(posedge clk);
        #1 trig1 = 1'b1;
        repeat (1000) @(posedge clk);
        #1 trig1 = 1'b0;
        repeat (20) @(negedge clk);
        check("held_frames", rise1 - d0, 1);
        check("held_drop", drop1, 0);
        check("held_busy_end", {31'd0, busy1}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/psc_trigger_tx.md
PSC_TRIGGER_TX -- requirements
Module: psc_trigger_tx

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of trigger channels, legal range 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 5, clk cycles per serial bit, legal minimum 2.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port evr_trigger  in  NUM_CH  asynchronous trigger inputs, one per channel.
REQ-007 SHALL have port psc_output  out  1  serial frame line, idle high.
REQ-008 SHALL have port busy  out  1  high while a frame or inter-frame gap is in progress.
REQ-009 SHALL have port drop_pulse  out  1  one-cycle pulse when a trigger edge is lost.

Function
REQ-010 SHALL pass each evr_trigger bit through a 2-flop synchroniser, then a registered rising-edge detector.
REQ-011 SHALL set pending[i] on a detected edge of channel i; pending[i] clears when channel i is granted.
- If an edge and a grant hit the same channel in the same cycle, the set wins and pending stays 1.
REQ-012 SHALL pulse drop_pulse for 1 cycle on an edge of a channel whose pending is already 1 and is not being granted that cycle.
REQ-013 SHALL use FSM states IDLE, LOAD, SHIFT, GAP.
- IDLE -> LOAD when any pending bit is set.
- LOAD -> SHIFT after 1 cycle.
- SHIFT -> GAP after the last bit of the last byte.
- GAP -> IDLE after 2 bit periods.
REQ-014 SHALL grant in LOAD by round-robin: the first pending index at or above rr_ptr, wrapping; rr_ptr then becomes (grant+1) mod NUM_CH.
REQ-015 SHALL compose the frame as bytes:
- SYNC_BYTE;
- the channel index, zero-extended to 8 bits;
- seq, an 8-bit frame counter that increments after each frame and wraps 255 -> 0;
- the optional CRC byte (REQ-022).
REQ-016 SHALL serialise each byte as 10 bits: start 0, D0..D7 LSB first, stop 1. Each bit is held exactly CLK_DIV clk cycles.
REQ-017 SHALL drive the first start bit on the cycle after LOAD. A lone edge reaching an idle block yields the start bit 5 clk cycles after the first clk edge that samples evr_trigger high.
REQ-018 SHALL hold psc_output high in IDLE and GAP.
REQ-019 SHALL drive busy = 1 in LOAD, SHIFT and GAP, and 0 in IDLE.
REQ-020 SHALL keep accepting edges into pending while busy. A queued channel starts its frame immediately after GAP, with no extra idle cycle beyond IDLE -> LOAD.

Reset
REQ-021 SHALL, on any clk edge with reset = 0, including mid-frame:
- abandon the frame and enter IDLE;
- clear pending, synchronisers, rr_ptr and seq to 0;
- drive psc_output = 1, busy = 0 and drop_pulse = 0 on the following cycle.

Configuration
REQ-022 SHALL use macro PSC_TRIGGER_CRC_EN.
- Defined: append a 4th byte, CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no xorout) computed over the 3 preceding bytes.
- Undefined: the frame is 3 bytes and the CRC logic is absent.

Structure
REQ-023 SHALL place in shared package psc_trigger_pkg:
- the FSM state enum;
- the CRC poly constant;
- bits-per-byte (10) and gap-bits (2) constants;
- a function returning frame byte count from the CRC setting.
REQ-024 SHALL instantiate one sub-module psc_trigger_crc8: a bytewise CRC update with crc_in, data_in -> crc_out.

Verification
REQ-025 CRC on, CLK_DIV = 5, single edge on ch2 after reset:
- bytes A5 02 00 A2 appear on psc_output;
- busy is high for 1 + 200 + 10 = 211 cycles.
REQ-026 CRC off, edges on ch0 and ch3 in the same cycle:
- the ch0 frame (A5 00 00) is sent, then the ch3 frame (A5 03 01);
- rr_ptr = 0 afterwards.
REQ-027 Two edges on ch1 while ch1 is pending and busy:
- drop_pulse fires once;
- exactly one further ch1 frame is sent.
REQ-028 A 256-frame run on ch0:
- the seq byte runs 00..FF;
- the 257th frame carries 00.
REQ-029 reset = 0 asserted in the middle of byte 2:
- psc_output = 1 and busy = 0 on the next cycle;
- the next frame after release carries seq 00.
REQ-030 CLK_DIV = 2, NUM_CH = 1, edge held high for 1000 cycles:
- exactly one frame is sent;
- drop_pulse stays 0.
